equal_window_n: RTL
===================

// Module: equal_window_n
// PURPOSE
//  Clocked N-input temporal "equal" operator for race-logic / pulse-width coded datapaths.
//  Asserts y when all N channels arrive within TOL aclk cycles of the first arrival
//  inside one gamma window. TOL=0 gives strict equality. Generalises the 2-input equal primitive.
//  The window is opened by gamma reset rst.
//  Sits between the column/neuron race logic and downstream WTA/inhibit stages.
// PARAMETERS
//  N          2   number of input channels (>=2)
//  TOL        0   max arrival spread in aclk cycles for a match (>=0)
//  PULSE_OUT  0   0: y is a level held until rst; 1: y is a single-cycle pulse
//  SW         $clog2(TOL+1) (min 1), localparam: width of spread
// PORTS
//  aclk     in   1    clock, all state on rising edge
//  grst     in   1    asynchronous active-low global reset
//  rst      in   1    synchronous active-high gamma-window clear
//  in       in   N    channel arrival signals, sampled each aclk edge
//  y        out  1    match indication (see PULSE_OUT)
//  done     out  1    decision made (MATCH or FAIL), level until rst
//  fail     out  1    window closed without match, level until rst
//  spread   out  SW   last-minus-first arrival offset of the match, valid with y/done&~fail
//  arrived  out  N    sticky per-channel arrival flags
// BEHAVIOUR
//  - grst=0 (async): state=IDLE; win=0; y=0, done=0, fail=0, spread=0, arrived=0.
//  - rst=1 at an edge: same clear as grst, synchronously. Inputs sampled in that cycle are ignored.
//  - Arrival: the channel is sampled at 1 at an edge. arrived[i] is set and sticky; later 0s are ignored.
//  - State is 2-bit and has four values: IDLE, OPEN, MATCH, FAIL.
//    win counts cycles since the first arrival. Width is $clog2(TOL+2).
//  - IDLE:
//    * No input high: stay in IDLE.
//    * All N high: go to MATCH, spread=0.
//    * Some (not all) high: go to OPEN if TOL>0, with win=0. Go to FAIL if TOL=0.
//  - OPEN: each edge samples at offset k=win+1. Update arrived first, then:
//    * All arrived and k<=TOL: go to MATCH, spread=k.
//    * Not all arrived and k>=TOL: go to FAIL.
//    * Otherwise: win<=k and stay in OPEN.
//  - MATCH and FAIL are terminal until rst or grst. Further inputs are ignored (arrived still updates).
//  - Outputs are registered; latency is 1 cycle.
//    y/done rise on the edge that samples the completing arrival.
//    Offset is measured from the first arrival's sample edge.
//    PULSE_OUT=0: y=(state==MATCH). PULSE_OUT=1: y=1 only on the IDLE/OPEN->MATCH transition cycle.
//  - done=(state==MATCH||FAIL); fail=(state==FAIL). y and fail are never both 1.
//  - Simultaneous rst and completing arrival: rst wins, no match is reported.
//  - win never wraps: OPEN is left by offset TOL at the latest.
//  - A gamma window with no arrivals leaves all outputs 0 indefinitely.
// TESTING
//  1. Reset: grst pulse low mid-cycle, no clock edge needed.
//     -> all outputs 0 at once. After grst release with in=0 for 10 cycles -> y=done=0.
//  2. N=2, TOL=0: in=2'b11 on one edge -> next cycle y=1, done=1, spread=0.
//     in=01 then 11 on the next edge -> fail=1, y=0.
//  3. N=4, TOL=3: channels arrive at offsets 0,1,3,2 -> y=1 on the offset-3 edge, spread=3.
//     Hold 5 cycles, then rst -> all 0.
//  4. N=4, TOL=3: channels 0-2 arrive at offset 0, ch3 never arrives -> fail=1 on the offset-3 edge.
//     A later ch3 arrival does not change y/fail.
//  5. rst mid-OPEN (offset 1 of TOL=3) -> IDLE, arrived=0.
//     Fresh all-at-once arrival -> y=1, spread=0. rst on the same edge as the completing arrival -> y stays 0.
//  6. PULSE_OUT=1, N=2, TOL=2: arrivals at offsets 0,2 -> y high exactly 1 cycle, done held, spread=2.

Source files
------------

// File: rtl/equal_window_n.sv
`default_nettype none
// ============================================================================
// Module  : equal_window_n
// Brief   : N-input temporal "equal" operator with an arrival-spread tolerance
//           inside one gamma window (race-logic datapaths).
// Revision: 1.0 - initial release
// ============================================================================
module equal_window_n #(
    parameter  int N         = 2,
    parameter  int TOL       = 0,
    parameter  int PULSE_OUT = 0,
    localparam int SW        = (TOL < 1) ? 1 : $clog2(TOL + 1)
) (
    input  logic          aclk,
    input  logic          grst,
    input  logic          rst,
    input  logic [N-1:0]  in,
    output logic          y,
    output logic          done,
    output logic          fail,
    output logic [SW-1:0] spread,
    output logic [N-1:0]  arrived
);

    localparam int WW = $clog2(TOL + 2);
    localparam logic [WW-1:0] TOL_W = WW'(TOL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        MATCH = 2'd2,
        FAIL  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [WW-1:0] win, win_nx, k;
    logic [SW-1:0] spread_nx;
    logic [N-1:0]  arrived_nx;
    logic          all_in;
    logic          enter_match;

    always_ff @(posedge aclk or negedge grst) begin
        if (!grst) begin
            state   <= IDLE;
            win     <= '0;
            spread  <= '0;
            arrived <= '0;
            done    <= 1'b0;
            fail    <= 1'b0;
        end else if (rst) begin
            state   <= IDLE;
            win     <= '0;
            spread  <= '0;
            arrived <= '0;
            done    <= 1'b0;
            fail    <= 1'b0;
        end else begin
            state   <= state_nx;
            win     <= win_nx;
            spread  <= spread_nx;
            arrived <= arrived_nx;
            done    <= (state_nx == MATCH) || (state_nx == FAIL);
            fail    <= (state_nx == FAIL);
        end
    end

    // The completing arrival is judged against the flags including this edge's sample.
    always_comb begin
        arrived_nx  = arrived | in;
        all_in      = &arrived_nx;
        k           = win + 1'b1;
        state_nx    = state;
        win_nx      = win;
        spread_nx   = spread;
        enter_match = 1'b0;
        case (state)
            IDLE: begin
                if (|in) begin
                    if (all_in) begin
                        state_nx    = MATCH;
                        spread_nx   = '0;
                        enter_match = 1'b1;
                    end else if (TOL > 0) begin
                        state_nx = OPEN;
                        win_nx   = '0;
                    end else begin
                        state_nx = FAIL;
                    end
                end
            end
            OPEN: begin
                if (all_in && (k <= TOL_W)) begin
                    state_nx    = MATCH;
                    spread_nx   = k[SW-1:0];
                    enter_match = 1'b1;
                end else if (!all_in && (k >= TOL_W)) begin
                    state_nx = FAIL;
                end else begin
                    win_nx = k;
                end
            end
            default: begin
            end
        endcase
    end

    generate
        if (PULSE_OUT != 0) begin : g_pulse
            always_ff @(posedge aclk or negedge grst) begin
                if (!grst) begin
                    y <= 1'b0;
                end else if (rst) begin
                    y <= 1'b0;
                end else begin
                    y <= enter_match;
                end
            end
        end else begin : g_level
            always_ff @(posedge aclk or negedge grst) begin
                if (!grst) begin
                    y <= 1'b0;
                end else if (rst) begin
                    y <= 1'b0;
                end else begin
                    y <= (state_nx == MATCH);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire
